sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Parametrised serial-in/parallel-out deserializer; successor to the fixed 8-bit SIPO unit.
- Adds configurable width and bit order, a shift-enable strobe, and a bit counter that detects word completion.
- Completed words go to a holding register with a valid/ready handshake and a sticky overrun flag.
- Sits between the UART RX bit sampler (drives data_in/shift_en at mid-bit) and the RX FIFO/consumer.

Parameters:
- WIDTH, 8, bits per word; legal range WIDTH >= 2.
- LSB_FIRST, 1, 1 = first received bit lands in q[0] (UART order); 0 = first received bit lands in q[WIDTH-1].
- CNT_W, max(1, $clog2(WIDTH)), width of bit_count; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial data bit, sampled when shift_en=1.
- shift_en  input  1  shift strobe; one bit consumed per clk edge where high.
- clear  input  1  synchronous flush of partial word and overrun flag.
- q  output  WIDTH  live shift register contents.
- bit_count  output  CNT_W  bits received into current partial word, 0..WIDTH-1.
- word_out  output  WIDTH  last completed word; stable while word_valid=1.
- word_valid  output  1  completed word available.
- word_ready  input  1  consumer accepts word_out on edge where word_valid=1.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset asserted, asynchronously: q=0, bit_count=0, word_out=0, word_valid=0, overrun=0. A partial word in progress at reset is discarded.
- Edge priority: clear, then shift_en.
- clear=1: q<=0, bit_count<=0, overrun<=0. Any shift_en bit on the same edge is discarded. word_out and word_valid are unaffected; the handshake still operates on that edge.
- Shift with shift_en=1 and LSB_FIRST=1: q <= {data_in, q[WIDTH-1:1]}.
- Shift with shift_en=1 and LSB_FIRST=0: q <= {q[WIDTH-2:0], data_in}.
- shift_en=0: q and bit_count hold.
- bit_count increments per shift. On the shift where bit_count==WIDTH-1 (word-complete event), bit_count wraps to 0 and the new q value, including this bit, is the completed word.
- Latency: word_out and word_valid update on the same edge that samples the final bit. They are visible the cycle after that bit is presented.
- Handshake: word_valid=1 and word_ready=1 at an edge means the word is consumed and word_valid<=0, unless a new word completes on that edge.
- Word complete while word_valid=0: load word_out, word_valid<=1.
- Word complete with word_valid=1 and word_ready=1 on the same edge: load new word_out, word_valid stays 1, no overrun.
- Word complete with word_valid=1 and word_ready=0: new word dropped, word_out unchanged, overrun<=1.
- overrun clears only on reset or clear.
- word_ready while word_valid=0: ignored.
- After completion, q keeps its contents; the next word shifts over it. Continuous back-to-back words need no idle cycle.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Default params; reset; shift 0xA5 LSB-first (1,0,1,0,0,1,0,1) on 8 consecutive edges, word_ready=0 -> after 8th edge word_valid=1, word_out=0xA5, bit_count=0, overrun=0.
- Same word with shift_en toggling every other cycle and data_in randomised on shift_en=0 cycles -> word_out=0xA5; q and bit_count unchanged on idle cycles.
- Hold word_ready=0; send 0xA5, then 0x3C -> overrun=1, word_out=0xA5; pulse word_ready -> word_valid=0; pulse clear -> overrun=0.
- 0xA5 pending; assert word_ready exactly on the edge completing 0x3C -> word_out=0x3C, word_valid=1, overrun=0; one more ready -> word_valid=0.
- Assert reset asynchronously between edges after 4 bits of a word -> all outputs 0 before the next edge. Release, send 0x5A -> word_out=0x5A. Repeat with clear after 3 bits plus shift_en on the clear edge -> bit_count=0; next 8 bits produce a correct word.
- WIDTH=12, LSB_FIRST=0; shift 0xABC MSB-first -> word_out=0xABC, bit_count wraps from 11 to 0.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with configurable width and bit order.
// Completed words are held in a registered output slot with a valid/ready handshake.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] bit_count,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             word_done;

  // Handshake: word_out is held stable while word_valid is high; the word is
  // consumed on any edge where word_valid and word_ready are both high. A word
  // completing on that same edge replaces it directly.
  always_comb begin
    q_d       = q_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    word_done = 1'b0;

    if (clear) begin
      q_d   = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (shift_en) begin
      if (LSB_FIRST) begin
        q_d = {data_in, q_q[WIDTH-1:1]};
      end else begin
        q_d = {q_q[WIDTH-2:0], data_in};
      end
      if (cnt_q == LAST_BIT) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end

    if (word_done) begin
      if (!valid_q || word_ready) begin
        word_d  = q_d;
        valid_d = 1'b1;
      end else begin
        // Consumer stalled: keep the pending word, drop the new one.
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q     <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q          = q_q;
  assign bit_count  = cnt_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;

endmodule
